// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite encodings shared by the master FSM and the register-file side
package axi_lite_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase wait counter; expired flags the last cycle a phase may wait
module phase_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + W'(1);
    end
    // count is zero in the first cycle of a phase, so this is the TIMEOUT_CYCLES-th cycle
    assign expired = enable && count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding command-to-AXI4-Lite bridge with per-phase timeout
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp
);
    state_t state, state_next;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic aw_done, w_done, expired, timed;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // every AXI-facing control is decoded from registered state, so reset drops them at once
    assign cmd_ready     = state == IDLE;
    assign rsp_valid     = state == RESP;
    assign m_axi_awvalid = state == WRITE && !aw_done;
    assign m_axi_wvalid  = state == WRITE && !w_done;
    assign m_axi_bready  = state == WRESP;
    assign m_axi_arvalid = state == RADDR;
    assign m_axi_rready  = state == RDATA;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_arprot  = PROT_DEFAULT;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;
    assign timed = state inside {WRITE, WRESP, RADDR, RDATA};

    phase_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(m_axi_aclk),
        .rst(m_axi_rst),
        .clear(state != state_next),
        .enable(timed),
        .expired(expired)
    );

    always_ff @(posedge m_axi_aclk or posedge m_axi_rst) begin
        if (m_axi_rst) state <= IDLE;
        else state <= state_next;
    end

    // handshakes are tested before expiry so a last-cycle handshake still succeeds
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = cmd_wr ? WRITE : RADDR;
            WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WRESP;
                     else if (expired) state_next = RESP;
            WRESP:   if (b_hs || expired) state_next = RESP;
            RADDR:   if (ar_hs) state_next = RDATA;
                     else if (expired) state_next = RESP;
            RDATA:   if (r_hs || expired) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_rst) begin
        if (m_axi_rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            aw_done <= state == WRITE && (aw_done || aw_hs);
            w_done  <= state == WRITE && (w_done || w_hs);
            if (b_hs) begin
                rsp_rdata   <= '0;
                rsp_err     <= m_axi_bresp != RESP_OKAY;
                rsp_timeout <= 1'b0;
            end else if (r_hs) begin
                rsp_rdata   <= m_axi_rdata;
                rsp_err     <= m_axi_rresp != RESP_OKAY;
                rsp_timeout <= 1'b0;
            end else if (expired && state_next == RESP) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized scoreboard bench with a delay-programmable AXI4-Lite slave
module tb_axi_lite_master;
    localparam int T = 8;

    logic clk = 1'b0;
    logic m_axi_rst;
    logic cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;

    axi_lite_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .m_axi_aclk(clk), .m_axi_rst(m_axi_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic err;
        logic tmo;
        int lat;
        int aw_c, w_c, b_c, ar_c, r_c;
        int hs_aw, hs_w, hs_b, hs_ar, hs_r;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, done_cnt = 0, n_txn = 0, txn_id = 0;
    int cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r, cfg_hold;
    logic [1:0] cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata, cur_addr, cur_wdata;
    int n_aw, n_w, n_ar, n_bready, n_rready, hs_aw, hs_w, hs_b, hs_ar, hs_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int mn(input int a, input int b);
        return a < b ? a : b;
    endfunction

    // Expected outcome from the slave's programmed wait counts: each phase may wait at most T cycles
    function automatic exp_t model(input bit wr, input int aw, input int w, input int b, input int ar,
                                   input int r, input logic [1:0] br, input logic [1:0] rr,
                                   input logic [31:0] rd);
        exp_t e;
        int wp;
        e = '0;
        if (wr) begin
            wp = (aw > w ? aw : w) + 1;
            e.aw_c = mn(aw + 1, T);
            e.w_c = mn(w + 1, T);
            e.hs_aw = aw < T ? 1 : 0;
            e.hs_w = w < T ? 1 : 0;
            if (wp > T) begin
                e.tmo = 1'b1;
                e.lat = 1 + T;
            end else begin
                e.b_c = mn(b + 1, T);
                e.hs_b = b < T ? 1 : 0;
                e.tmo = b >= T;
                e.lat = 1 + wp + e.b_c;
            end
            e.err = e.tmo || br != 2'b00;
        end else begin
            e.ar_c = mn(ar + 1, T);
            e.hs_ar = ar < T ? 1 : 0;
            if (ar >= T) begin
                e.tmo = 1'b1;
                e.lat = 1 + T;
            end else begin
                e.r_c = mn(r + 1, T);
                e.hs_r = r < T ? 1 : 0;
                e.tmo = r >= T;
                e.rdata = e.tmo ? 32'h0 : rd;
                e.lat = 2 + ar + e.r_c;
            end
            e.err = e.tmo || rr != 2'b00;
        end
        return e;
    endfunction

    // Slave: each ready/valid rises after a programmed number of cycles of the corresponding phase
    initial begin
        int sl_id, b_n, r_n;
        bit aw_got, w_got, b_arm, r_arm;
        sl_id = 0; b_n = 0; r_n = 0; aw_got = 0; w_got = 0; b_arm = 0; r_arm = 0;
        {awready, wready, bvalid, arready, rvalid} = '0;
        bresp = 2'b00; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            if (sl_id != txn_id) begin
                sl_id = txn_id;
                {n_aw, n_w, n_ar, n_bready, n_rready} = '0;
                {hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
                {aw_got, w_got, b_arm, r_arm} = '0;
            end
            bvalid = b_arm && b_n >= cfg_b;
            bresp = cfg_bresp;
            if (b_arm) b_n++;
            if (bready) n_bready++;
            if (bvalid && bready) begin hs_b++; b_arm = 0; end
            rvalid = r_arm && r_n >= cfg_r;
            rresp = cfg_rresp;
            rdata = cfg_rdata;
            if (r_arm) r_n++;
            if (rready) n_rready++;
            if (rvalid && rready) begin hs_r++; r_arm = 0; end
            awready = 1'b0;
            if (awvalid) begin
                check("awaddr_stable", awaddr, cur_addr);
                awready = n_aw == cfg_aw;
                n_aw++;
                if (awready) begin hs_aw++; aw_got = 1; check("awprot", awprot, 0); end
            end
            wready = 1'b0;
            if (wvalid) begin
                check("wdata_stable", wdata, cur_wdata);
                wready = n_w == cfg_w;
                n_w++;
                if (wready) begin hs_w++; w_got = 1; check("wstrb", wstrb, 4'hF); end
            end
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_arm = 1; b_n = 0; end
            arready = 1'b0;
            if (arvalid) begin
                check("araddr_stable", araddr, cur_addr);
                arready = n_ar == cfg_ar;
                n_ar++;
                if (arready) begin hs_ar++; r_arm = 1; r_n = 0; check("arprot", arprot, 0); end
            end
        end
    end

    // Monitor: compares every rsp_valid cycle with the scoreboard head, pops on rsp_ready
    initial begin
        exp_t e;
        int hold_n;
        bit seen;
        hold_n = 0; seen = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = 1'b0;
            if (m_axi_rst) begin
                hold_n = 0;
                seen = 0;
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 with empty scoreboard");
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        check("latency", cyc - acc_cyc, e.lat);
                        seen = 1;
                        hold_n = 0;
                    end
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                    if (hold_n >= cfg_hold) begin
                        rsp_ready = 1'b1;
                        check("awvalid_cycles", n_aw, e.aw_c);
                        check("wvalid_cycles", n_w, e.w_c);
                        check("bready_cycles", n_bready, e.b_c);
                        check("arvalid_cycles", n_ar, e.ar_c);
                        check("rready_cycles", n_rready, e.r_c);
                        check("aw_beats", hs_aw, e.hs_aw);
                        check("w_beats", hs_w, e.hs_w);
                        check("b_beats", hs_b, e.hs_b);
                        check("ar_beats", hs_ar, e.hs_ar);
                        check("r_beats", hs_r, e.hs_r);
                        void'(exp_q.pop_front());
                        seen = 0;
                        done_cnt++;
                    end
                    hold_n++;
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int k;
        cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, expected 1", k);
        end
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d, input int aw, input int w,
                       input int b, input int ar, input int r, input logic [1:0] br, input logic [1:0] rr,
                       input logic [31:0] rd, input int hold);
        int k;
        cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_ar = ar; cfg_r = r;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd; cfg_hold = hold;
        cur_addr = a; cur_wdata = d;
        txn_id++;
        exp_q.push_back(model(wr, aw, w, b, ar, r, br, rr, rd));
        issue(wr, a, d);
        n_txn++;
        k = 0;
        while (done_cnt < n_txn && k < 200) begin @(negedge clk); k++; end
        if (done_cnt < n_txn) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: no response after %0d cycles, expected one", k);
            exp_q.delete();
            done_cnt = n_txn;
        end
    endtask

    initial begin
        m_axi_rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_hold = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0; cur_addr = '0; cur_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_timeout}, 8'h00);
        check("reset_rdata", rsp_rdata, 32'h0);
        m_axi_rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1'b1);

        run(1, 32'h2, 32'h1234_5678, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0);
        run(1, 32'h40, 32'hA5A5_0F0F, 2, 0, 1, 0, 0, 2'b00, 2'b00, 32'h0, 1);
        run(0, 32'h1, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEAD_BEEF, 4);
        run(0, 32'h8, 32'h0, 1, 1, 1, 1, 2, 2'b00, 2'b10, 32'h0BAD_F00D, 0);
        run(0, 32'hC, 32'h0, 0, 0, 0, T - 1, T - 1, 2'b00, 2'b00, 32'h7777_0001, 0);
        run(1, 32'h10, 32'h0000_00FF, T - 1, 3, T - 1, 0, 0, 2'b11, 2'b00, 32'h0, 2);
        run(1, 32'h14, 32'h1111_2222, 0, 0, T, 0, 0, 2'b00, 2'b00, 32'h0, 0);
        run(1, 32'h18, 32'h3333_4444, 1, T, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0);
        run(0, 32'h24, 32'h0, 0, 0, 0, 0, T, 2'b00, 2'b00, 32'h5555_6666, 0);
        run(0, 32'h20, 32'h0, 0, 0, 0, 100, 0, 2'b00, 2'b00, 32'h0, 1);

        // abort a write while awvalid is held, then prove the next read is clean
        cfg_aw = 6; cfg_w = 6; cfg_b = 0; cfg_hold = 0;
        cur_addr = 32'h30; cur_wdata = 32'hCAFE_0001;
        txn_id++;
        issue(1, 32'h30, 32'hCAFE_0001);
        @(negedge clk);
        check("awvalid_before_reset", awvalid, 1'b1);
        #1 m_axi_rst = 1'b1;
        #1 check("midreset_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_timeout}, 8'h00);
        check("midreset_rdata", rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        m_axi_rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_midreset", cmd_ready, 1'b1);
        run(0, 32'h34, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1357_9BDF, 0);

        for (int i = 0; i < 40; i++)
            run($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, the data bus width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, the address bus width.
REQ-003 SHALL have parameter AXI_STRB_WIDTH, default AXI_DATA_WIDTH/8, the write strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum wait cycles per AXI phase before abort.
REQ-005 SHALL use one clock; reset is asynchronous and active-high: m_axi_aclk  in  1  clock; m_axi_rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have command ports: cmd_valid in 1 request; cmd_ready out 1 accept; cmd_wr in 1 (1 write, 0 read); cmd_addr in AXI_ADDR_WIDTH; cmd_wdata in AXI_DATA_WIDTH.
REQ-007 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out AXI_DATA_WIDTH; rsp_err out 1 (non-OKAY or timeout); rsp_timeout out 1.
REQ-008 SHALL have AXI4-Lite master ports: m_axi_awvalid/awready/awaddr/awprot[2:0], wvalid/wready/wdata/wstrb, bvalid/bready/bresp[1:0], arvalid/arready/araddr/arprot[2:0], rvalid/rready/rdata/rresp[1:0].

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
REQ-010 SHALL assert cmd_ready only in IDLE; cmd_valid&cmd_ready latches cmd_wr/addr/wdata and moves to WRITE (cmd_wr=1) or RADDR (cmd_wr=0) next cycle.
REQ-011 SHALL in WRITE assert awvalid and wvalid together from the first WRITE cycle, dropping each independently on its own handshake; move to WRESP once both handshakes have occurred (same or different cycles).
REQ-012 SHALL hold awaddr/wdata stable while the corresponding valid is high; wstrb all ones; awprot=arprot=3'b000.
REQ-013 SHALL in WRESP assert bready; bvalid&bready captures rsp_err=(bresp!=2'b00), rsp_rdata=0, move to RESP.
REQ-014 SHALL in RADDR assert arvalid until arready, then RDATA; in RDATA assert rready; rvalid&rready captures rdata and rsp_err=(rresp!=2'b00), move to RESP.
REQ-015 SHALL in RESP assert rsp_valid holding rsp_* stable until rsp_ready, then return to IDLE; back-to-back command earliest the cycle after return.
REQ-016 SHALL never assert bready outside WRESP or rready outside RDATA.
REQ-017 SHALL count cycles in each of WRITE, WRESP, RADDR, RDATA (counter cleared on state entry, width clog2(TIMEOUT_CYCLES+1)); on reaching TIMEOUT_CYCLES, deassert all AXI valids/readies, set rsp_err=1, rsp_timeout=1, go to RESP.
REQ-018 SHALL treat a handshake in the same cycle as the timeout reaching TIMEOUT_CYCLES as success (handshake wins).
REQ-019 SHALL guarantee minimum latency: write with zero-wait slave accept-to-rsp_valid 3 cycles; read 3 cycles.

Reset
REQ-020 SHALL on m_axi_rst force state IDLE and clear all AXI valid/ready outputs, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, latched command and counter to 0, immediately (asynchronously), including mid-transaction.
REQ-021 SHALL present cmd_ready=1 the first clock after reset release.

Structure
REQ-022 SHALL place FSM state encoding, RESP_OKAY=2'b00 and default prot constant in a shared package axi_lite_pkg reused by the register file side.
REQ-023 SHALL implement the timeout counter as sub-module phase_timer (clear, enable, expired output).

Verification
REQ-024 Write cmd addr=0x2, data=0x1234_5678, slave awready/wready same cycle, bresp=00 -> one AW/W beat with that addr/data, wstrb=4'hF, rsp_valid with rsp_err=0.
REQ-025 Write, slave asserts wready 2 cycles before awready -> wvalid drops after W handshake, awvalid held with stable addr, single bready handshake, rsp_err=0.
REQ-026 Read addr=0x1, slave rdata=0xDEAD_BEEF, rresp=00, rsp_ready low 4 cycles -> rsp_rdata=0xDEAD_BEEF held stable with rsp_valid until rsp_ready.
REQ-027 Read with rresp=2'b10 -> rsp_err=1, rsp_timeout=0.
REQ-028 TIMEOUT_CYCLES=8, slave never asserts arready -> arvalid high exactly 8 cycles then low, rsp_err=1, rsp_timeout=1, returns to IDLE.
REQ-029 Assert m_axi_rst while awvalid high mid-write -> all valids low immediately; after release, new read completes normally.
